// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI mode-0 frame sequencer driving single-cycle register bus strobes
module spi_reg_ctrl #(
    parameter int DATA_W   = 8,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_reset,
    input  logic              spi_read,
    input  logic              spi_write,
    input  logic              spi_busy,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [6:0]        reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              xfer_done,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDATA
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_bit_cnt;
    logic [DATA_W-1:0]   r_sh_in;
    logic [DATA_W-1:0]   r_sh_out;
    logic                r_re_pend;
    logic                r_load;

    logic                w_busy_fall;
    logic                w_in_frame;
    logic                w_last_bit;
    logic                w_word_done;
    logic                w_cmd_write;
    logic [DATA_W-1:0]   w_sh_in_next;

    // miso_oe is the one-cycle-delayed busy level, so it doubles as the edge detector
    assign w_busy_fall  = miso_oe & ~spi_busy;
    assign w_in_frame   = (r_state != S_IDLE);
    assign w_last_bit   = (r_state == S_CMD) ? (r_bit_cnt == 4'd7) : (r_bit_cnt == LAST_DATA);
    assign w_word_done  = w_in_frame & spi_read & w_last_bit;
    assign w_sh_in_next = {r_sh_in[DATA_W-2:0], mosi};
    assign w_cmd_write  = r_sh_in[6];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_busy_fall) begin
            w_next = S_IDLE;
        end else if (spi_reset) begin
            w_next = S_CMD;
        end else if (w_word_done && (r_state == S_CMD)) begin
            w_next = w_cmd_write ? S_WDATA : S_RDATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            reg_addr  <= 7'd0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            xfer_done <= 1'b0;
            frame_err <= 1'b0;
            r_bit_cnt <= 4'd0;
            r_sh_in   <= '0;
            r_sh_out  <= '0;
            r_re_pend <= 1'b0;
            r_load    <= 1'b0;
        end else begin
            miso_oe   <= spi_busy;
            reg_we    <= 1'b0;
            reg_re    <= r_re_pend;
            r_re_pend <= 1'b0;
            r_load    <= reg_re;
            xfer_done <= 1'b0;
            frame_err <= 1'b0;

            if (r_load) begin
                r_sh_out <= reg_rdata;
            end
            // increment after the write strobe so the address is stable while it is high
            if (reg_we && AUTO_INC) begin
                reg_addr <= reg_addr + 7'd1;
            end
            if (r_state != S_RDATA) begin
                miso <= 1'b0;
            end

            if (w_busy_fall) begin
                xfer_done <= w_in_frame && (r_bit_cnt == 4'd0);
                frame_err <= (r_bit_cnt != 4'd0);
                r_bit_cnt <= 4'd0;
                reg_re    <= 1'b0;
            end else if (spi_reset) begin
                r_bit_cnt <= 4'd0;
            end else if (spi_read) begin
                r_sh_in <= w_sh_in_next;
                if (w_in_frame) begin
                    r_bit_cnt <= w_last_bit ? 4'd0 : r_bit_cnt + 4'd1;
                end
                if (w_word_done) begin
                    case (r_state)
                        S_CMD: begin
                            reg_addr <= w_sh_in_next[6:0];
                            if (!w_cmd_write) begin
                                reg_re <= 1'b1;
                            end
                        end
                        S_WDATA: begin
                            reg_wdata <= w_sh_in_next;
                            reg_we    <= 1'b1;
                        end
                        S_RDATA: begin
                            if (AUTO_INC) begin
                                reg_addr <= reg_addr + 7'd1;
                            end
                            r_re_pend <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (spi_write && (r_state == S_RDATA)) begin
                miso     <= r_sh_out[DATA_W-1];
                r_sh_out <= r_sh_out << 1;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - directed scoreboard bench for spi_reg_ctrl
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_reset = 1'b0;
    logic       spi_read = 1'b0;
    logic       spi_write = 1'b0;
    logic       spi_busy = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       xfer_done;
    logic       frame_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [14:0] wr_q[$];
    logic [6:0]  re_q[$];
    logic [1:0]  end_q[$];

    spi_reg_ctrl #(.DATA_W(8), .AUTO_INC(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_reset (spi_reset),
        .spi_read  (spi_read),
        .spi_write (spi_write),
        .spi_busy  (spi_busy),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .xfer_done (xfer_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_re) reg_rdata <= 8'(reg_addr) + 8'hA0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (reg_we) begin
            if (wr_q.size() == 0) chk("unexpected_reg_we", {reg_addr, reg_wdata}, 32'hFFFF_FFFF);
            else chk("reg_we_addr_data", {reg_addr, reg_wdata}, wr_q.pop_front());
        end
        if (reg_re) begin
            if (re_q.size() == 0) chk("unexpected_reg_re", reg_addr, 32'hFFFF_FFFF);
            else chk("reg_re_addr", reg_addr, re_q.pop_front());
        end
        if (xfer_done || frame_err) begin
            if (end_q.size() == 0) chk("unexpected_frame_end", {xfer_done, frame_err}, 32'hFFFF_FFFF);
            else chk("done_err", {xfer_done, frame_err}, end_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        spi_reset = 1'b1;
        tick();
        spi_reset = 1'b0;
        repeat (3) tick();
    endtask

    task automatic start_frame();
        spi_busy = 1'b1;
        tick();
        pulse_reset();
    endtask

    task automatic stop_frame();
        spi_busy = 1'b0;
        repeat (6) tick();
    endtask

    task automatic send_bit(input logic b, output logic seen);
        mosi = b;
        seen = miso;
        spi_read = 1'b1;
        tick();
        spi_read = 1'b0;
        repeat (4) tick();
        spi_write = 1'b1;
        tick();
        spi_write = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, output logic [7:0] got);
        logic s;
        got = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            send_bit(v[i], s);
            got = {got[6:0], s};
        end
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] exp_miso[$];

        repeat (3) tick();
        chk("rst_outputs", {miso, miso_oe, reg_addr, reg_wdata, reg_we, reg_re, xfer_done, frame_err}, 0);
        rst = 1'b0;
        tick();

        // single write
        wr_q.push_back({7'h05, 8'h3C});
        end_q.push_back(2'b10);
        start_frame();
        chk("miso_oe_follows_busy", miso_oe, 1);
        send_bits(8'h85, 8, got);
        chk("cmd_wr_addr", reg_addr, 7'h05);
        send_bits(8'h3C, 8, got);
        stop_frame();
        chk("addr_after_inc", reg_addr, 7'h06);
        chk("miso_oe_low", miso_oe, 0);

        // burst read with prefetch
        re_q.push_back(7'h10); re_q.push_back(7'h11);
        re_q.push_back(7'h12); re_q.push_back(7'h13);
        exp_miso = '{8'hB0, 8'hB1, 8'hB2};
        end_q.push_back(2'b10);
        start_frame();
        send_bits(8'h10, 8, got);
        for (int k = 0; k < 3; k++) begin
            send_bits(8'h00, 8, got);
            chk("miso_byte", got, exp_miso.pop_front());
        end
        stop_frame();
        chk("miso_idle", miso, 0);

        // address wrap
        wr_q.push_back({7'h7F, 8'h11});
        wr_q.push_back({7'h00, 8'h22});
        end_q.push_back(2'b10);
        start_frame();
        send_bits(8'hFF, 8, got);
        send_bits(8'h11, 8, got);
        send_bits(8'h22, 8, got);
        stop_frame();
        chk("wrap_addr", reg_addr, 7'h01);

        // partial word
        end_q.push_back(2'b01);
        start_frame();
        send_bits(8'h82, 8, got);
        send_bits(8'hF8, 5, got);
        stop_frame();

        // mid-frame abort
        wr_q.push_back({7'h01, 8'h55});
        end_q.push_back(2'b10);
        start_frame();
        send_bits(8'hE0, 3, got);
        pulse_reset();
        send_bits(8'h81, 8, got);
        send_bits(8'h55, 8, got);
        stop_frame();

        // rst during a read data word
        re_q.push_back(7'h03);
        start_frame();
        send_bits(8'h03, 8, got);
        send_bits(8'h00, 4, got);
        rst = 1'b1;
        tick();
        chk("rst_mid_read", {miso, miso_oe, reg_addr, reg_wdata, reg_we, reg_re, xfer_done, frame_err}, 0);
        rst = 1'b0;
        send_bits(8'h00, 2, got);
        stop_frame();

        re_q.push_back(7'h02);
        re_q.push_back(7'h03);
        end_q.push_back(2'b10);
        start_frame();
        send_bits(8'h02, 8, got);
        send_bits(8'h00, 8, got);
        chk("post_rst_miso", got, 8'hA2);
        stop_frame();

        chk("wr_q_empty", wr_q.size(), 0);
        chk("re_q_empty", re_q.size(), 0);
        chk("end_q_empty", end_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
